// File: rtl/snake_body_engine.sv
// snake_body_engine: snake body circular buffer with step, grow and collision control emitting erase/draw pixels
module snake_body_engine #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int X_MAX = 159,
  parameter int Y_MAX = 119,
  parameter int MAX_LEN = 64,
  parameter int INIT_X = 80,
  parameter int INIT_Y = 60,
  parameter int WRAP = 0,
  parameter logic [2:0] SNAKE_COLOUR = 3'b111
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       step,
  input  logic [1:0]                 dir,
  input  logic [X_W-1:0]             food_x,
  input  logic [Y_W-1:0]             food_y,
  output logic                       plot,
  output logic [X_W-1:0]             x_out,
  output logic [Y_W-1:0]             y_out,
  output logic [2:0]                 colour,
  output logic                       busy,
  output logic                       ate,
  output logic                       game_over,
  output logic [$clog2(MAX_LEN):0]   length
);
  localparam int PW = $clog2(MAX_LEN);
  localparam logic [X_W-1:0] XM = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YM = Y_W'(Y_MAX);
  localparam logic [X_W-1:0] IX = X_W'(INIT_X);
  localparam logic [Y_W-1:0] IY = Y_W'(INIT_Y);
  localparam logic [PW:0] ML = (PW+1)'(MAX_LEN);
  typedef enum logic [2:0] {INIT, IDLE, CALC, SCAN, ERASE, DRAW, DEAD} state_t;
  state_t state, state_n;
  logic [X_W-1:0] bx [MAX_LEN];
  logic [Y_W-1:0] by [MAX_LEN];
  logic [PW-1:0] hp, idx, tail;
  logic [PW:0] cnt;
  logic [1:0] cur_dir, dir_n;
  logic [X_W-1:0] hx, nx, nh_x;
  logic [Y_W-1:0] hy, ny, nh_y;
  logic wall, eat_n, grow_n, grow, eat, hit;
  always_comb begin
    hx = bx[hp];
    hy = by[hp];
    dir_n = (dir == (cur_dir ^ 2'b01)) ? cur_dir : dir;
    nx = dir_n == 2'd0 ? (hx == '0 ? XM : hx - 1'b1) : dir_n == 2'd1 ? (hx == XM ? '0 : hx + 1'b1) : hx;
    ny = dir_n == 2'd2 ? (hy == '0 ? YM : hy - 1'b1) : dir_n == 2'd3 ? (hy == YM ? '0 : hy + 1'b1) : hy;
    wall = (dir_n == 2'd0 && hx == '0) || (dir_n == 2'd1 && hx == XM) ||
           (dir_n == 2'd2 && hy == '0) || (dir_n == 2'd3 && hy == YM);
    eat_n = nx == food_x && ny == food_y;
    grow_n = eat_n && length < ML;
    hit = cnt != '0 && bx[idx] == nh_x && by[idx] == nh_y;
    tail = hp - length[PW-1:0] + 1'b1;
    busy = state != IDLE;
    game_over = state == DEAD;
    state_n = state;
    case (state)
      INIT:    state_n = IDLE;
      IDLE:    state_n = step ? CALC : IDLE;
      CALC:    state_n = (wall && WRAP == 0) ? DEAD : SCAN;
      SCAN:    state_n = hit ? DEAD : cnt > (PW+1)'(1) ? SCAN : grow ? DRAW : ERASE;
      ERASE:   state_n = DRAW;
      DRAW:    state_n = IDLE;
      DEAD:    state_n = DEAD;
      default: state_n = INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cur_dir <= 2'd1;
      hp <= '0;
      length <= (PW+1)'(1);
      bx[0] <= IX;
      by[0] <= IY;
      plot <= 1'b0;
      x_out <= '0;
      y_out <= '0;
      colour <= 3'b000;
      ate <= 1'b0;
    end else begin
      state <= state_n;
      plot <= 1'b0;
      ate <= 1'b0;
      case (state)
        INIT: begin
          plot <= 1'b1;
          x_out <= IX;
          y_out <= IY;
          colour <= SNAKE_COLOUR;
        end
        CALC: begin
          cur_dir <= dir_n;
          nh_x <= nx;
          nh_y <= ny;
          grow <= grow_n;
          eat <= eat_n;
          idx <= hp;
          cnt <= grow_n ? length : length - 1'b1;
        end
        SCAN: begin
          idx <= idx - 1'b1;
          cnt <= cnt - 1'b1;
        end
        ERASE: begin
          plot <= 1'b1;
          x_out <= bx[tail];
          y_out <= by[tail];
          colour <= 3'b000;
        end
        DRAW: begin
          hp <= hp + 1'b1;
          bx[hp + 1'b1] <= nh_x;
          by[hp + 1'b1] <= nh_y;
          plot <= 1'b1;
          x_out <= nh_x;
          y_out <= nh_y;
          colour <= SNAKE_COLOUR;
          ate <= eat;
          length <= length + {{PW{1'b0}}, grow};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_snake_body_engine.sv
// tb_snake_body_engine: directed self-checking bench for snake_body_engine
module tb_snake_body_engine;
  logic clk;
  logic rst [3];
  logic stp [3];
  logic [1:0] dr [3];
  logic [7:0] fx [3];
  logic [6:0] fy [3];
  logic pl [3];
  logic [7:0] xo [3];
  logic [6:0] yo [3];
  logic [2:0] co [3];
  logic bz [3];
  logic at [3];
  logic go [3];
  logic [6:0] ln0, ln1;
  logic [2:0] ln2;
  int n_tests = 0, n_fail = 0;
  int np, bcyc, atc;
  int px [4];
  int py [4];
  int pc [4];

  snake_body_engine dut0 (.clk(clk), .reset(rst[0]), .step(stp[0]), .dir(dr[0]), .food_x(fx[0]), .food_y(fy[0]),
    .plot(pl[0]), .x_out(xo[0]), .y_out(yo[0]), .colour(co[0]), .busy(bz[0]), .ate(at[0]), .game_over(go[0]), .length(ln0));
  snake_body_engine #(.WRAP(1)) dut1 (.clk(clk), .reset(rst[1]), .step(stp[1]), .dir(dr[1]), .food_x(fx[1]), .food_y(fy[1]),
    .plot(pl[1]), .x_out(xo[1]), .y_out(yo[1]), .colour(co[1]), .busy(bz[1]), .ate(at[1]), .game_over(go[1]), .length(ln1));
  snake_body_engine #(.MAX_LEN(4)) dut2 (.clk(clk), .reset(rst[2]), .step(stp[2]), .dir(dr[2]), .food_x(fx[2]), .food_y(fy[2]),
    .plot(pl[2]), .x_out(xo[2]), .y_out(yo[2]), .colour(co[2]), .busy(bz[2]), .ate(at[2]), .game_over(go[2]), .length(ln2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lenof(input int id);
    return id == 0 ? int'(ln0) : id == 1 ? int'(ln1) : int'(ln2);
  endfunction

  task automatic test_reset(input int id);
    @(negedge clk); rst[id] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tests++; if (bz[id] !== 1'b1) begin n_fail++; $display("FAIL rst_busy[%0d] got %b exp 1", id, bz[id]); end
    n_tests++; if (pl[id] !== 1'b0) begin n_fail++; $display("FAIL rst_plot[%0d] got %b exp 0", id, pl[id]); end
    n_tests++; if ({xo[id], yo[id], co[id]} !== 18'd0) begin n_fail++; $display("FAIL rst_xyc[%0d] got %0d,%0d,%0d exp 0,0,0", id, xo[id], yo[id], co[id]); end
    n_tests++; if (at[id] !== 1'b0 || go[id] !== 1'b0) begin n_fail++; $display("FAIL rst_flags[%0d] ate %b go %b exp 0 0", id, at[id], go[id]); end
    n_tests++; if (lenof(id) !== 1) begin n_fail++; $display("FAIL rst_len[%0d] got %0d exp 1", id, lenof(id)); end
    rst[id] = 1'b0;
    @(negedge clk);
    n_tests++; if (pl[id] !== 1'b1 || xo[id] !== 8'd80 || yo[id] !== 7'd60 || co[id] !== 3'b111)
      begin n_fail++; $display("FAIL init_plot[%0d] got %b %0d,%0d,%0d exp 1 80,60,7", id, pl[id], xo[id], yo[id], co[id]); end
    n_tests++; if (bz[id] !== 1'b0) begin n_fail++; $display("FAIL init_idle[%0d] busy %b exp 0", id, bz[id]); end
    @(negedge clk);
    n_tests++; if (pl[id] !== 1'b0 || xo[id] !== 8'd80) begin n_fail++; $display("FAIL init_hold[%0d] plot %b x %0d exp 0 80", id, pl[id], xo[id]); end
  endtask

  task automatic do_step(input int id, input logic [1:0] d, input bit hold);
    int k;
    np = 0; bcyc = 0; atc = 0;
    @(negedge clk); stp[id] = 1'b1; dr[id] = d;
    @(negedge clk); if (!hold) stp[id] = 1'b0;
    for (k = 0; k < 200; k++) begin
      if (bz[id]) bcyc++;
      if (pl[id]) begin
        if (np < 4) begin px[np] = int'(xo[id]); py[np] = int'(yo[id]); pc[np] = int'(co[id]); end
        np++;
      end
      if (at[id]) atc++;
      if (!bz[id] || go[id]) break;
      @(negedge clk);
    end
    stp[id] = 1'b0;
    n_tests++; if (k >= 200) begin n_fail++; $display("FAIL step_timeout[%0d] busy %b after %0d cycles", id, bz[id], k); end
  endtask

  task automatic test_move;
    do_step(0, 2'd1, 0);
    n_tests++; if (np !== 2) begin n_fail++; $display("FAIL move_np got %0d exp 2", np); end
    n_tests++; if (px[0] !== 80 || py[0] !== 60 || pc[0] !== 0) begin n_fail++; $display("FAIL move_erase got %0d,%0d,%0d exp 80,60,0", px[0], py[0], pc[0]); end
    n_tests++; if (px[1] !== 81 || py[1] !== 60 || pc[1] !== 7) begin n_fail++; $display("FAIL move_draw got %0d,%0d,%0d exp 81,60,7", px[1], py[1], pc[1]); end
    n_tests++; if (bcyc !== 4) begin n_fail++; $display("FAIL move_busy got %0d exp 4", bcyc); end
    n_tests++; if (lenof(0) !== 1 || atc !== 0) begin n_fail++; $display("FAIL move_len len %0d ate %0d exp 1 0", lenof(0), atc); end
  endtask

  task automatic test_reverse;
    do_step(0, 2'd0, 0);
    n_tests++; if (px[1] !== 82 || py[1] !== 60) begin n_fail++; $display("FAIL rev_draw got %0d,%0d exp 82,60", px[1], py[1]); end
    do_step(0, 2'd2, 0);
    n_tests++; if (px[1] !== 82 || py[1] !== 59) begin n_fail++; $display("FAIL up_draw got %0d,%0d exp 82,59", px[1], py[1]); end
    n_tests++; if (px[0] !== 82 || py[0] !== 60) begin n_fail++; $display("FAIL up_erase got %0d,%0d exp 82,60", px[0], py[0]); end
  endtask

  task automatic test_grow;
    test_reset(0);
    do_step(0, 2'd1, 0);
    do_step(0, 2'd1, 0);
    fx[0] = 8'd83; fy[0] = 7'd60;
    do_step(0, 2'd1, 1);
    n_tests++; if (np !== 1) begin n_fail++; $display("FAIL grow_np got %0d exp 1", np); end
    n_tests++; if (px[0] !== 83 || py[0] !== 60 || pc[0] !== 7) begin n_fail++; $display("FAIL grow_draw got %0d,%0d,%0d exp 83,60,7", px[0], py[0], pc[0]); end
    n_tests++; if (atc !== 1) begin n_fail++; $display("FAIL grow_ate got %0d exp 1", atc); end
    n_tests++; if (lenof(0) !== 2) begin n_fail++; $display("FAIL grow_len got %0d exp 2", lenof(0)); end
    n_tests++; if (bcyc !== 3) begin n_fail++; $display("FAIL grow_busy got %0d exp 3", bcyc); end
    fx[0] = 8'd10; fy[0] = 7'd10;
    do_step(0, 2'd1, 0);
    n_tests++; if (np !== 2 || px[0] !== 82 || px[1] !== 84) begin n_fail++; $display("FAIL after_grow np %0d erase %0d draw %0d exp 2 82 84", np, px[0], px[1]); end
    n_tests++; if (lenof(0) !== 2 || bcyc !== 4 || atc !== 0) begin n_fail++; $display("FAIL after_grow len %0d busy %0d ate %0d exp 2 4 0", lenof(0), bcyc, atc); end
  endtask

  task automatic test_wall;
    test_reset(0);
    repeat (79) do_step(0, 2'd1, 0);
    n_tests++; if (px[1] !== 159 || go[0] !== 1'b0) begin n_fail++; $display("FAIL wall_reach x %0d go %b exp 159 0", px[1], go[0]); end
    do_step(0, 2'd1, 0);
    n_tests++; if (go[0] !== 1'b1 || np !== 0) begin n_fail++; $display("FAIL wall_dead go %b np %0d exp 1 0", go[0], np); end
    do_step(0, 2'd2, 0);
    n_tests++; if (go[0] !== 1'b1 || np !== 0 || bz[0] !== 1'b1) begin n_fail++; $display("FAIL dead_hold go %b np %0d busy %b exp 1 0 1", go[0], np, bz[0]); end
  endtask

  task automatic test_wrap;
    test_reset(1);
    repeat (79) do_step(1, 2'd1, 0);
    do_step(1, 2'd1, 0);
    n_tests++; if (go[1] !== 1'b0 || np !== 2) begin n_fail++; $display("FAIL wrap_alive go %b np %0d exp 0 2", go[1], np); end
    n_tests++; if (px[0] !== 159 || px[1] !== 0 || py[1] !== 60) begin n_fail++; $display("FAIL wrap_draw erase %0d draw %0d,%0d exp 159 0,60", px[0], px[1], py[1]); end
  endtask

  task automatic test_self_collision;
    test_reset(0);
    for (int i = 1; i <= 4; i++) begin fx[0] = 8'(80 + i); fy[0] = 7'd60; do_step(0, 2'd1, 0); end
    n_tests++; if (lenof(0) !== 5) begin n_fail++; $display("FAIL self_len got %0d exp 5", lenof(0)); end
    fx[0] = 8'd10; fy[0] = 7'd10;
    do_step(0, 2'd3, 0);
    do_step(0, 2'd0, 0);
    n_tests++; if (go[0] !== 1'b0 || px[1] !== 83 || py[1] !== 61) begin n_fail++; $display("FAIL self_path go %b head %0d,%0d exp 0 83,61", go[0], px[1], py[1]); end
    do_step(0, 2'd2, 0);
    n_tests++; if (go[0] !== 1'b1 || np !== 0) begin n_fail++; $display("FAIL self_hit go %b np %0d exp 1 0", go[0], np); end
  endtask

  task automatic test_tail_chase;
    test_reset(0);
    for (int i = 1; i <= 3; i++) begin fx[0] = 8'(80 + i); fy[0] = 7'd60; do_step(0, 2'd1, 0); end
    fx[0] = 8'd10; fy[0] = 7'd10;
    do_step(0, 2'd3, 0);
    do_step(0, 2'd0, 0);
    do_step(0, 2'd2, 0);
    n_tests++; if (go[0] !== 1'b0 || np !== 2) begin n_fail++; $display("FAIL tail_alive go %b np %0d exp 0 2", go[0], np); end
    n_tests++; if (px[0] !== 82 || py[0] !== 60 || px[1] !== 82 || py[1] !== 60) begin n_fail++; $display("FAIL tail_xy erase %0d,%0d draw %0d,%0d exp 82,60 82,60", px[0], py[0], px[1], py[1]); end
    n_tests++; if (bcyc !== 6 || lenof(0) !== 4) begin n_fail++; $display("FAIL tail_busy busy %0d len %0d exp 6 4", bcyc, lenof(0)); end
  endtask

  task automatic test_saturate;
    test_reset(2);
    for (int i = 1; i <= 5; i++) begin
      fx[2] = 8'(80 + i); fy[2] = 7'd60;
      do_step(2, 2'd1, 0);
      n_tests++; if (atc !== 1) begin n_fail++; $display("FAIL sat_ate[%0d] got %0d exp 1", i, atc); end
      n_tests++; if (lenof(2) !== (i < 3 ? i + 1 : 4)) begin n_fail++; $display("FAIL sat_len[%0d] got %0d exp %0d", i, lenof(2), i < 3 ? i + 1 : 4); end
    end
    n_tests++; if (np !== 2 || px[0] !== 81 || px[1] !== 85) begin n_fail++; $display("FAIL sat_erase np %0d erase %0d draw %0d exp 2 81 85", np, px[0], px[1]); end
  endtask

  task automatic test_reset_mid_scan;
    @(negedge clk); stp[0] = 1'b1; dr[0] = 2'd2;
    @(negedge clk); stp[0] = 1'b0;
    @(negedge clk);
    n_tests++; if (bz[0] !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b exp 1", bz[0]); end
    rst[0] = 1'b1;
    @(negedge clk);
    n_tests++; if (bz[0] !== 1'b1 || pl[0] !== 1'b0 || go[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rst busy %b plot %b go %b exp 1 0 0", bz[0], pl[0], go[0]); end
    n_tests++; if (lenof(0) !== 1) begin n_fail++; $display("FAIL mid_len got %0d exp 1", lenof(0)); end
    rst[0] = 1'b0;
    @(negedge clk);
    n_tests++; if (pl[0] !== 1'b1 || xo[0] !== 8'd80 || yo[0] !== 7'd60) begin n_fail++; $display("FAIL mid_init plot %b %0d,%0d exp 1 80,60", pl[0], xo[0], yo[0]); end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin rst[i] = 1'b1; stp[i] = 1'b0; dr[i] = 2'd1; fx[i] = 8'd10; fy[i] = 7'd10; end
    test_reset(0);
    test_move;
    test_reverse;
    test_grow;
    test_wall;
    test_wrap;
    test_self_collision;
    test_tail_chase;
    test_saturate;
    test_reset_mid_scan;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
